// File: rtl/damage_gate.sv
// Hit gate for the health counter: turns raw slime contact levels into one-cycle
// damage pulses and adds an invulnerability window, a sprite blink and a saturating hit tally.
module damage_gate #(
    parameter int unsigned INVULN_CYCLES = 300_000_000,
    parameter int unsigned BLINK_CYCLES  = 12_500_000,
    parameter int unsigned CNT_W         = 29
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       slime_hit,
    input  logic             game_active,
    output logic [1:0]       slim_damage,
    output logic             invuln,
    output logic             sprite_on,
    output logic [7:0]       hit_total
);

    localparam logic [CNT_W-1:0] INV_LOAD = CNT_W'(INVULN_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLK_LOAD = CNT_W'(BLINK_CYCLES - 1);

    typedef enum logic {
        ARMED = 1'b0,
        GUARD = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] inv_cnt, inv_cnt_d;
    logic [CNT_W-1:0] blk_cnt, blk_cnt_d;
    logic [1:0]       dmg_d;
    logic             invuln_d;
    logic             sprite_d;
    logic [7:0]       total_d;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ARMED;
            inv_cnt     <= '0;
            blk_cnt     <= '0;
            slim_damage <= 2'b00;
            invuln      <= 1'b0;
            sprite_on   <= 1'b1;
            hit_total   <= 8'd0;
        end else begin
            state       <= state_d;
            inv_cnt     <= inv_cnt_d;
            blk_cnt     <= blk_cnt_d;
            slim_damage <= dmg_d;
            invuln      <= invuln_d;
            sprite_on   <= sprite_d;
            hit_total   <= total_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state;
        inv_cnt_d = inv_cnt;
        blk_cnt_d = blk_cnt;
        dmg_d     = 2'b00;
        invuln_d  = invuln;
        sprite_d  = sprite_on;
        total_d   = hit_total;

        if (!game_active) begin
            state_d   = ARMED;
            inv_cnt_d = '0;
            blk_cnt_d = '0;
            invuln_d  = 1'b0;
            sprite_d  = 1'b1;
        end else begin
            unique case (state)
                ARMED: begin
                    if (slime_hit != 2'b00) begin
                        state_d   = GUARD;
                        dmg_d     = slime_hit;
                        inv_cnt_d = INV_LOAD;
                        blk_cnt_d = BLK_LOAD;
                        invuln_d  = 1'b1;
                        sprite_d  = 1'b0;
                        if (hit_total != 8'hFF) begin
                            total_d = hit_total + 8'd1;
                        end
                    end else begin
                        invuln_d = 1'b0;
                        sprite_d = 1'b1;
                    end
                end
                GUARD: begin
                    if (blk_cnt == '0) begin
                        sprite_d  = ~sprite_on;
                        blk_cnt_d = BLK_LOAD;
                    end else begin
                        blk_cnt_d = blk_cnt - CNT_W'(1);
                    end
                    // Window end wins over a blink toggle on the same edge
                    if (inv_cnt == '0) begin
                        state_d  = ARMED;
                        invuln_d = 1'b0;
                        sprite_d = 1'b1;
                    end else begin
                        inv_cnt_d = inv_cnt - CNT_W'(1);
                    end
                end
                default: state_d = ARMED;
            endcase
        end
    end

endmodule

// File: tb/tb_damage_gate.sv
// Scoreboard bench for damage_gate: a window/phase reference model predicts the
// outputs after every edge, and a separate monitor compares them against the DUT.
module tb_damage_gate;

    localparam int unsigned INV = 8;
    localparam int unsigned BLK = 2;

    typedef struct packed {
        logic [1:0] dmg;
        logic       inv;
        logic       spr;
        logic [7:0] tot;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [1:0] slime_hit;
    logic       game_active;
    logic [1:0] slim_damage;
    logic       invuln;
    logic       sprite_on;
    logic [7:0] hit_total;

    damage_gate #(
        .INVULN_CYCLES(INV),
        .BLINK_CYCLES (BLK),
        .CNT_W        (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .slime_hit  (slime_hit),
        .game_active(game_active),
        .slim_damage(slim_damage),
        .invuln     (invuln),
        .sprite_on  (sprite_on),
        .hit_total  (hit_total)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cycle    = 0;
    int   pulses   = 0;

    // Reference model: remaining window cycles, cycles since hit, tally
    int   m_left  = 0;
    int   m_phase = 0;
    int   m_total = 0;

    function automatic exp_t model_step(input logic r, input logic ga, input logic [1:0] h);
        exp_t e;
        e.dmg = 2'b00;
        if (r) begin
            m_left = 0; m_phase = 0; m_total = 0;
        end else if (!ga) begin
            m_left = 0; m_phase = 0;
        end else if (m_left == 0) begin
            if (h != 2'b00) begin
                e.dmg   = h;
                m_left  = INV;
                m_phase = 0;
                m_total = (m_total < 255) ? m_total + 1 : 255;
            end
        end else begin
            m_left  = m_left - 1;
            m_phase = m_phase + 1;
        end
        e.inv = (m_left > 0);
        e.spr = (m_left > 0) ? (((m_phase / BLK) % 2) == 1) : 1'b1;
        e.tot = 8'(m_total);
        return e;
    endfunction

    task automatic step(input logic r, input logic ga, input logic [1:0] h);
        @(negedge clk);
        reset       = r;
        game_active = ga;
        slime_hit   = h;
        exp_q.push_back(model_step(r, ga, h));
    endtask

    // Monitor: each edge's result is compared once outputs settle
    always @(posedge clk) begin
        #1;
        cycle++;
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = exp_q.pop_front();
            a = {slim_damage, invuln, sprite_on, hit_total};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL outputs cycle %0d: got dmg=%b inv=%b spr=%b tot=%0d, want dmg=%b inv=%b spr=%b tot=%0d",
                          cycle, a.dmg, a.inv, a.spr, a.tot, e.dmg, e.inv, e.spr, e.tot);
            if (e.dmg != 2'b00) pulses++;
        end
    end

    initial begin
        reset = 1'b1; game_active = 1'b0; slime_hit = 2'b00;
        step(1, 0, 2'b00);
        step(1, 1, 2'b00);
        // single hit, full window with blink
        step(0, 1, 2'b01);
        repeat (12) step(0, 1, 2'b00);
        // held double contact: pulses every INV+1 cycles
        repeat (25) step(0, 1, 2'b11);
        repeat (10) step(0, 1, 2'b00);
        // hit inside the window is ignored
        step(0, 1, 2'b01);
        repeat (3) step(0, 1, 2'b00);
        step(0, 1, 2'b10);
        repeat (10) step(0, 1, 2'b00);
        // reset mid-window, then an immediate hit
        step(0, 1, 2'b10);
        repeat (3) step(0, 1, 2'b00);
        step(1, 1, 2'b00);
        step(0, 1, 2'b01);
        repeat (10) step(0, 1, 2'b00);
        // game_active low beats a hit, and cancels a window
        step(0, 0, 2'b01);
        step(0, 1, 2'b00);
        step(0, 1, 2'b11);
        repeat (3) step(0, 1, 2'b00);
        step(0, 0, 2'b00);
        repeat (3) step(0, 1, 2'b00);
        // tally saturation
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 2'(1 + (i % 3)));
            repeat (9) step(0, 1, 2'b00);
        end
        // random traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) != 0),
                 2'($urandom_range(0, 3)));
        end
        step(0, 1, 2'b00);
        begin
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            n_checks++;
            if (exp_q.size() == 0) n_pass++;
            else $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        n_checks++;
        if (pulses >= 300) n_pass++;
        else $display("FAIL pulse_count: got %0d expected pulses, want at least 300", pulses);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/damage_gate.md
Name: damage_gate

Overview:
Upstream stage of the health counter. Takes raw per-slime contact levels from the collision logic and turns them into clean, single-cycle `slim_damage` pulses for the health counter. After each hit it enforces a synthesizable invulnerability window, replacing any simulation-only delay. It also drives a blink enable for the player sprite and keeps a saturating hit tally for the status display.

Parameters:
INVULN_CYCLES, 300_000_000, invulnerability window length in clk cycles (3 s at 100 MHz); legal range ≥ 2
BLINK_CYCLES, 12_500_000, half-period of the sprite blink during invulnerability, in clk cycles; legal range ≥ 1
CNT_W, 29, counter width; must hold INVULN_CYCLES-1 and BLINK_CYCLES-1

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high; overrides everything
slime_hit  input  2  raw contact level, bit i = player overlaps slime i (may stay high many cycles)
game_active  input  1  high while a round is running; low disarms the block
slim_damage  output  2  registered; one-cycle pulse, bits = which slimes caused the hit
invuln  output  1  registered; high during the invulnerability window
sprite_on  output  1  registered; player sprite visibility (blink)
hit_total  output  8  registered; saturating count of accepted hits

Behaviour:
- Reset (clk edge with reset=1): state=ARMED, slim_damage=0, invuln=0, sprite_on=1, hit_total=0, both counters=0. Applies mid-window too; no pending pulse survives.
- States: ARMED, GUARD.
- ARMED, game_active=1, slime_hit≠0 at an edge:
  - slim_damage<=slime_hit (both bits when both slimes touch; still one pulse)
  - inv_cnt<=INVULN_CYCLES-1, invuln<=1, blk_cnt<=BLINK_CYCLES-1, sprite_on<=0
  - hit_total<=hit_total+1, saturating at 255
  - state<=GUARD
  - Latency: pulse is visible one cycle after slime_hit is sampled.
- ARMED otherwise: slim_damage<=0, invuln=0, sprite_on=1.
- GUARD:
  - slim_damage<=0 (pulse width exactly 1 cycle); slime_hit is ignored entirely.
  - If inv_cnt==0: state<=ARMED, invuln<=0, sprite_on<=1. Otherwise inv_cnt<=inv_cnt-1.
  - invuln is high for exactly INVULN_CYCLES cycles.
  - A contact held continuously produces pulses spaced INVULN_CYCLES+1 cycles apart.
- Blink in GUARD:
  - blk_cnt decrements each cycle.
  - At blk_cnt==0: sprite_on toggles and blk_cnt reloads BLINK_CYCLES-1.
  - The ARMED transition forces sprite_on=1, overriding any toggle on the same edge.
- game_active=0 at any edge (reset not asserted):
  - state<=ARMED, slim_damage<=0, invuln<=0, sprite_on<=1
  - hit_total holds its value
  - Takes priority over a simultaneous hit.
- Priority at one edge: reset > game_active=0 > hit/count logic.
- No combinational path from inputs to outputs.

Test Plan:
Bench parameters are INVULN_CYCLES=8, BLINK_CYCLES=2.

1. Reset, game_active=1, slime_hit=01 for 1 cycle at edge k -> slim_damage=01 for cycle k+1 only; invuln=1 for cycles k+1..k+8; hit_total=1; sprite_on=0,0,1,1,0,0,1,1 during the window, then 1.
2. slime_hit=11 held continuously -> pulses slim_damage=11 at cycles k+1, k+10, k+19 (spacing 9); hit_total increments by 1 per pulse.
3. slime_hit=10 pulses 3 cycles into the window -> no output pulse; invuln timing unchanged; hit_total unchanged.
4. reset asserted at cycle 4 of the window -> next cycle invuln=0, sprite_on=1, hit_total=0; a hit the following edge produces an immediate pulse.
5. game_active=0 coincident with slime_hit=01 in ARMED -> no pulse, invuln stays 0; game_active=0 mid-window -> invuln=0 on the next cycle, hit_total retained.
6. 300 separated hits -> hit_total saturates at 255 and stays there; slim_damage pulses still occur.
